// File: rtl/ccff_loader_if.sv
// Bitstream word handshake between a configuration source and ccff_loader.
interface ccff_loader_if #(
  parameter int WORD_W = 32
) ();
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/ccff_loader.sv
// Configuration-chain loader: serializes bitstream words MSB-first into ccff_head.
// Optional macro CCFF_READBACK_EN adds a CRC-16-CCITT signature of ccff_tail on rb_crc.
module ccff_loader #(
  parameter int CHAIN_LEN = 28,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic         start,
  ccff_loader_if.slave cfg,
  output logic         ccff_head,
  output logic         ccff_shift_en,
  input  logic         ccff_tail,
  output logic         busy,
  output logic         done,
  output logic [15:0]  rb_crc
);

  localparam int WL_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [WL_W-1:0]   word_left_q, word_left_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              head_q, head_d;
  logic              shen_q, shen_d;
  logic              accept;

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    word_left_d = word_left_q;
    shreg_d     = shreg_q;
    accept      = (state_q == LOAD) && cfg.cfg_valid;

    case (state_q)
      IDLE: begin
        bits_left_d = CNT_W'(CHAIN_LEN);
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          shreg_d     = cfg.cfg_data;
          word_left_d = (32'(bits_left_q) > WORD_W) ? WL_W'(WORD_W) : WL_W'(bits_left_q);
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d     = shreg_q << 1;
        bits_left_d = bits_left_q - CNT_W'(1);
        word_left_d = word_left_q - WL_W'(1);
        if (word_left_q == WL_W'(1)) begin
          state_d = (bits_left_q == CNT_W'(1)) ? DONE : LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state so the chain sees them with no input path.
    shen_d = (state_d == SHIFT);
    head_d = (state_d == SHIFT) && shreg_d[WORD_W-1];
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= IDLE;
      bits_left_q <= '0;
      word_left_q <= '0;
      shreg_q     <= '0;
      head_q      <= 1'b0;
      shen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      word_left_q <= word_left_d;
      shreg_q     <= shreg_d;
      head_q      <= head_d;
      shen_q      <= shen_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shen_q;
  assign cfg.cfg_ready = (state_q == LOAD);
  assign busy          = (state_q == LOAD) || (state_q == SHIFT);
  assign done          = (state_q == DONE);

`ifdef CCFF_READBACK_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_fb;

  // Tail is sampled in the same cycles the chain is clocked, yielding its old contents.
  always_comb begin
    crc_d  = crc_q;
    crc_fb = crc_q[15] ^ ccff_tail;
    if ((state_q == IDLE) && start) begin
      crc_d = 16'hFFFF;
    end else if (shen_q) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign rb_crc = crc_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_crc      = '0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: cycle table for a single-word load plus multi-cycle sequences.
module tb_ccff_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start28, start40, clr28;
  logic head28, se28, busy28, done28, tail28;
  logic head40, se40, busy40, done40, tail40;
  logic [15:0] rb28, rb40;
  logic [27:0] model28 = '0;
  logic [39:0] model40 = '0;

  ccff_loader_if #(.WORD_W(32)) if28 ();
  ccff_loader_if #(.WORD_W(32)) if40 ();

  ccff_loader #(.CHAIN_LEN(28), .WORD_W(32), .CNT_W(16)) u28 (
    .prog_clk(clk), .pReset(rst), .start(start28), .cfg(if28),
    .ccff_head(head28), .ccff_shift_en(se28), .ccff_tail(tail28),
    .busy(busy28), .done(done28), .rb_crc(rb28)
  );

  ccff_loader #(.CHAIN_LEN(40), .WORD_W(32), .CNT_W(16)) u40 (
    .prog_clk(clk), .pReset(rst), .start(start40), .cfg(if40),
    .ccff_head(head40), .ccff_shift_en(se40), .ccff_tail(tail40),
    .busy(busy40), .done(done40), .rb_crc(rb40)
  );

  // Chain models: element 0 sits next to ccff_head, the top element drives ccff_tail.
  assign tail28 = model28[27];
  assign tail40 = model40[39];
  always @(posedge clk) begin
    if (clr28)     model28 <= '0;
    else if (se28) model28 <= {model28[26:0], head28};
    if (se40)      model40 <= {model40[38:0], head40};
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc_ref(input logic [63:0] bits, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic load28(input logic [31:0] d, input int start_at,
                        output int se, output int dn, output logic [15:0] crc_done);
    se = 0; dn = 0; crc_done = '0;
    if28.cfg_data  = d;
    if28.cfg_valid = 1'b1;
    start28        = 1'b1;
    tick();
    for (int c = 1; c < 45; c++) begin
      start28 = (c == start_at);
      if (se28) se++;
      if (done28) begin
        dn++;
        crc_done = rb28;
      end
      tick();
    end
    start28        = 1'b0;
    if28.cfg_valid = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       valid;
    logic [4:0] exp;   // {cfg_ready, busy, ccff_shift_en, ccff_head, done}
  } vec_t;

  vec_t vec [33];

  initial begin
    logic [31:0] pat;
    logic [15:0] crc_a, crc_b, exp_a, exp_b;
    int se, dn, stall, acc, run, gap, gaps, done_cyc, n;
    bit  seen;

    pat = 32'hA5A5A5A5;
    vec[0]  = '{1'b1, 1'b1, 5'b00000};
    vec[1]  = '{1'b0, 1'b1, 5'b11000};
    for (int c = 2; c <= 29; c++) vec[c] = '{1'b0, 1'b1, {3'b011, pat[31-(c-2)], 1'b0}};
    vec[30] = '{1'b1, 1'b1, 5'b00001};
    vec[31] = '{1'b0, 1'b0, 5'b00000};
    vec[32] = '{1'b0, 1'b0, 5'b00000};

    rst = 1'b1; start28 = 1'b0; start40 = 1'b0; clr28 = 1'b0;
    if28.cfg_valid = 1'b0; if28.cfg_data = '0;
    if40.cfg_valid = 1'b0; if40.cfg_data = '0;
    tick(); tick();
    check("reset_outs28", {if28.cfg_ready, busy28, se28, head28, done28}, 5'b0);
    check("reset_outs40", {if40.cfg_ready, busy40, se40, head40, done40}, 5'b0);
    check("reset_rb28", rb28, 16'h0000);
    rst = 1'b0;
    tick();

    // Single word, cycle-accurate table; start in DONE must be ignored.
    if28.cfg_data = pat;
    for (int i = 0; i < 33; i++) begin
      start28        = vec[i].start;
      if28.cfg_valid = vec[i].valid;
      check($sformatf("vec_cyc%0d", i), {if28.cfg_ready, busy28, se28, head28, done28}, vec[i].exp);
      tick();
    end
    start28 = 1'b0; if28.cfg_valid = 1'b0;
    check("single_model", model28, 28'hA5A5A5A);

    // Multi-word with a 5-cycle valid stall before the second word.
    se = 0; dn = 0; stall = 0; acc = 0; run = 0; gap = 0; gaps = 0; done_cyc = 0; seen = 0;
    if40.cfg_data = 32'hFFFFFFFF; if40.cfg_valid = 1'b1; start40 = 1'b1;
    tick();
    start40 = 1'b0;
    for (int c = 1; c < 70; c++) begin
      if (if40.cfg_ready) begin
        if (acc == 0) begin
          if40.cfg_valid = 1'b1; if40.cfg_data = 32'hFFFFFFFF;
        end else if (stall < 5) begin
          if40.cfg_valid = 1'b0; stall++;
        end else begin
          if40.cfg_valid = 1'b1; if40.cfg_data = 32'h00FF0000;
        end
      end else begin
        if40.cfg_valid = 1'b0;
      end
      if (if40.cfg_ready && if40.cfg_valid) acc++;
      if (se40) begin
        se++;
        if (seen && run > 0) begin gap = run; gaps++; end
        run = 0; seen = 1;
      end else if (seen) begin
        run++;
      end
      if (done40) begin dn++; done_cyc = c; end
      tick();
    end
    if40.cfg_valid = 1'b0;
    check("multi_se_count", se, 40);
    check("multi_done_count", dn, 1);
    check("multi_done_cycle", done_cyc, 48);
    check("multi_gap_len", gap, 6);
    check("multi_gap_count", gaps, 1);
    check("multi_words", acc, 2);
    check("multi_model", model40, 40'hFFFFFFFF00);

    // Reset at the tenth shifted bit.
    if28.cfg_data = pat; if28.cfg_valid = 1'b1; start28 = 1'b1;
    tick();
    start28 = 1'b0; n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      if (se28) n++;
      if (n < 10) tick();
    end
    check("rst_reached_bit10", n, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0; if28.cfg_valid = 1'b0;
    check("rst_midshift_outs", {if28.cfg_ready, busy28, se28, done28}, 4'b0000);
    dn = 0;
    for (int c = 0; c < 5; c++) begin
      if (done28 || se28) dn++;
      tick();
    end
    check("rst_no_done", dn, 0);
    load28(32'h12345678, 0, se, dn, crc_a);
    check("post_rst_se", se, 28);
    check("post_rst_done", dn, 1);
    check("post_rst_model", model28, 28'h1234567);

    // Reset and start together: reset wins.
    rst = 1'b1; start28 = 1'b1;
    tick();
    rst = 1'b0; start28 = 1'b0;
    tick();
    check("rst_beats_start", {if28.cfg_ready, busy28}, 2'b00);

    // Start pulse during SHIFT is ignored.
    load28(32'h0F0F0F0F, 10, se, dn, crc_a);
    check("busy_start_se", se, 28);
    check("busy_start_done", dn, 1);
    check("busy_start_model", model28, 28'h0F0F0F0);

    // Readback: clear chain, load twice.
    clr28 = 1'b1;
    tick();
    clr28 = 1'b0;
`ifdef CCFF_READBACK_EN
    exp_a = crc_ref(64'd0, 28);
    exp_b = crc_ref(64'hA5A5A5A, 28);
`else
    exp_a = 16'h0000;
    exp_b = 16'h0000;
`endif
    load28(pat, 0, se, dn, crc_a);
    check("rb_first_done", crc_a, exp_a);
    tick(); tick(); tick();
    check("rb_first_hold", rb28, exp_a);
    load28(pat, 0, se, dn, crc_b);
    check("rb_second_done", crc_b, exp_b);
    check("rb_second_hold", rb28, exp_b);
    check("rb_second_model", model28, 28'hA5A5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
